// File: rtl/x_bus_caster.sv
// rtl/x_bus_caster.sv - X-bus caster: column-tag match, ifmap FIFO toward the PE, held result word back to the bus
module x_bus_caster #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_COL    = 4,
    parameter int FIFO_DEPTH = 2,
    parameter int CW         = $clog2(NUM_COL),
    parameter int CNTW       = $clog2(FIFO_DEPTH + 1),
    parameter int PW         = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_we,
    input  logic [CW-1:0]         cfg_col_id,
    input  logic                  CASTER_en,
    input  logic [CW-1:0]         col,
    input  logic [DATA_WIDTH-1:0] data_B2C,
    output logic                  PE_ready,
    input  logic                  ret_rd,
    output logic [DATA_WIDTH-1:0] data_C2B,
    output logic                  ret_valid,
    output logic [DATA_WIDTH-1:0] pe_ifmap,
    output logic                  pe_valid,
    input  logic                  pe_ack,
    input  logic [DATA_WIDTH-1:0] pe_res,
    input  logic                  pe_res_valid,
    output logic                  pe_res_ready,
    output logic                  err
);

    logic [CW-1:0]         id_q, id_d;
    logic [CNTW-1:0]       cnt_q, cnt_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic                  hold_full_q, hold_full_d;
    logic                  err_q, err_d;

    logic full, hit, sel, pop, push, push_drop, load, rd_ok, rd_empty;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full         = (cnt_q == CNTW'(FIFO_DEPTH));
    assign PE_ready     = !full;
    assign pe_valid     = (cnt_q != '0);
    assign pe_ifmap     = pe_valid ? mem_q[rd_ptr_q] : '0;
    assign ret_valid    = hold_full_q;
    assign pe_res_ready = !hold_full_q;
    assign data_C2B     = hold_full_q ? hold_q : '0;
    assign err          = err_q;

    // Matching uses the ID registered before this edge; a same-cycle cfg_we only affects later cycles.
    assign sel       = (col == id_q);
    assign hit       = CASTER_en && sel;
    assign pop       = pe_valid && pe_ack;
    // A full FIFO still accepts a hit when the head leaves in the same cycle.
    assign push      = hit && (!full || pop);
    assign push_drop = hit && full && !pop;
    assign load      = pe_res_valid && !hold_full_q;
    assign rd_ok     = ret_rd && sel && hold_full_q;
    assign rd_empty  = ret_rd && sel && !hold_full_q;

    always_comb begin
        id_d        = id_q;
        cnt_d       = cnt_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        mem_d       = mem_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        err_d       = err_q;
        if (cfg_we) begin
            id_d        = cfg_col_id;
            cnt_d       = '0;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            hold_full_d = 1'b0;
            err_d       = 1'b0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = data_B2C;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            if (push && !pop) begin
                cnt_d = cnt_q + CNTW'(1);
            end else if (pop && !push) begin
                cnt_d = cnt_q - CNTW'(1);
            end
            if (load) begin
                hold_d      = pe_res;
                hold_full_d = 1'b1;
            end else if (rd_ok) begin
                hold_full_d = 1'b0;
            end
            if (push_drop || rd_empty) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            id_q        <= '0;
            cnt_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            err_q       <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            id_q        <= id_d;
            cnt_q       <= cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            err_q       <= err_d;
            mem_q       <= mem_d;
        end
    end

endmodule

// File: tb/tb_x_bus_caster.sv
// tb/tb_x_bus_caster.sv - directed self-checking bench for x_bus_caster
module tb_x_bus_caster;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_we;
    logic [1:0]  cfg_col_id;
    logic        CASTER_en;
    logic [1:0]  col;
    logic [15:0] data_B2C;
    logic        PE_ready;
    logic        ret_rd;
    logic [15:0] data_C2B;
    logic        ret_valid;
    logic [15:0] pe_ifmap;
    logic        pe_valid;
    logic        pe_ack;
    logic [15:0] pe_res;
    logic        pe_res_valid;
    logic        pe_res_ready;
    logic        err;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    x_bus_caster dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_col_id(cfg_col_id),
        .CASTER_en(CASTER_en), .col(col), .data_B2C(data_B2C), .PE_ready(PE_ready),
        .ret_rd(ret_rd), .data_C2B(data_C2B), .ret_valid(ret_valid),
        .pe_ifmap(pe_ifmap), .pe_valid(pe_valid), .pe_ack(pe_ack),
        .pe_res(pe_res), .pe_res_valid(pe_res_valid), .pe_res_ready(pe_res_ready),
        .err(err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] c, input logic [15:0] d);
        CASTER_en = 1'b1; col = c; data_B2C = d;
        step();
        CASTER_en = 1'b0;
    endtask

    task automatic ack();
        pe_ack = 1'b1;
        step();
        pe_ack = 1'b0;
    endtask

    task automatic cfg(input logic [1:0] id);
        cfg_we = 1'b1; cfg_col_id = id;
        step();
        cfg_we = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cfg_we = 1'b0; cfg_col_id = '0; CASTER_en = 1'b0; col = '0;
        data_B2C = '0; ret_rd = 1'b0; pe_ack = 1'b0; pe_res = '0; pe_res_valid = 1'b0;
        step(); step();
        // T1 reset
        chk("rst_pe_ready", PE_ready, 1);
        chk("rst_pe_valid", pe_valid, 0);
        chk("rst_pe_ifmap", pe_ifmap, 0);
        chk("rst_err", err, 0);
        chk("rst_ret_valid", ret_valid, 0);
        chk("rst_data_c2b", data_C2B, 0);
        chk("rst_pe_res_ready", pe_res_ready, 1);
        rst = 1'b0;

        // T2 match / mismatch
        cfg(2'd2);
        push(2'd2, 16'h00A5);
        chk("t2_valid", pe_valid, 1);
        chk("t2_ifmap", pe_ifmap, 16'h00A5);
        chk("t2_ready", PE_ready, 1);
        push(2'd1, 16'h0011);
        chk("t2_miss_ifmap", pe_ifmap, 16'h00A5);
        chk("t2_miss_ready", PE_ready, 1);
        data_B2C = 16'h0077; col = 2'd2;
        step();
        chk("t2_noen_ready", PE_ready, 1);
        ack();
        chk("t2_pop_valid", pe_valid, 0);
        ack();
        chk("t2_ack_empty_valid", pe_valid, 0);
        chk("t2_ack_empty_err", err, 0);

        // T3 full
        push(2'd2, 16'h0001);
        push(2'd2, 16'h0002);
        chk("t3_full_ready", PE_ready, 0);
        chk("t3_head", pe_ifmap, 16'h0001);
        push(2'd2, 16'h0003);
        chk("t3_ovf_err", err, 1);
        chk("t3_ovf_head", pe_ifmap, 16'h0001);
        ack();
        chk("t3_second", pe_ifmap, 16'h0002);
        ack();
        chk("t3_empty_valid", pe_valid, 0);
        chk("t3_empty_ifmap", pe_ifmap, 0);
        chk("t3_empty_ready", PE_ready, 1);
        chk("t3_err_sticky", err, 1);
        cfg(2'd2);
        chk("t3_cfg_clr_err", err, 0);

        // T4 push+pop while full
        push(2'd2, 16'h0001);
        push(2'd2, 16'h0002);
        pe_ack = 1'b1;
        push(2'd2, 16'h0003);
        pe_ack = 1'b0;
        chk("t4_ready", PE_ready, 0);
        chk("t4_err", err, 0);
        chk("t4_head", pe_ifmap, 16'h0002);
        ack();
        chk("t4_next", pe_ifmap, 16'h0003);
        chk("t4_next_ready", PE_ready, 1);
        ack();
        chk("t4_empty", pe_valid, 0);

        // T5 result return
        pe_res = 16'hBEEF; pe_res_valid = 1'b1;
        step();
        chk("t5_ret_valid", ret_valid, 1);
        chk("t5_res_ready", pe_res_ready, 0);
        chk("t5_data", data_C2B, 16'hBEEF);
        pe_res = 16'h1234;
        step();
        pe_res_valid = 1'b0;
        chk("t5_no_overwrite", data_C2B, 16'hBEEF);
        ret_rd = 1'b1; col = 2'd1;
        step();
        chk("t5_wrong_col_valid", ret_valid, 1);
        chk("t5_wrong_col_err", err, 0);
        col = 2'd2;
        #1;
        chk("t5_read_data", data_C2B, 16'hBEEF);
        step();
        ret_rd = 1'b0;
        chk("t5_after_valid", ret_valid, 0);
        chk("t5_after_data", data_C2B, 0);
        chk("t5_after_ready", pe_res_ready, 1);
        ret_rd = 1'b1;
        step();
        ret_rd = 1'b0;
        chk("t5_rd_empty_err", err, 1);

        // T6 cfg and reset mid-operation
        cfg(2'd2);
        push(2'd2, 16'h0A0A);
        push(2'd2, 16'h0B0B);
        pe_res = 16'hCAFE; pe_res_valid = 1'b1;
        step();
        pe_res_valid = 1'b0;
        cfg_we = 1'b1; cfg_col_id = 2'd3;
        push(2'd2, 16'h0009);
        cfg_we = 1'b0;
        chk("t6_cfg_valid", pe_valid, 0);
        chk("t6_cfg_ready", PE_ready, 1);
        chk("t6_cfg_hold", ret_valid, 0);
        chk("t6_cfg_err", err, 0);
        push(2'd2, 16'h0044);
        chk("t6_old_id_miss", pe_valid, 0);
        push(2'd3, 16'h0033);
        chk("t6_new_id_hit", pe_ifmap, 16'h0033);
        push(2'd3, 16'h0055);
        pe_res = 16'hCAFE; pe_res_valid = 1'b1;
        step();
        pe_res_valid = 1'b0;
        rst = 1'b1;
        push(2'd3, 16'h0066);
        rst = 1'b0;
        chk("t6_rst_valid", pe_valid, 0);
        chk("t6_rst_ready", PE_ready, 1);
        chk("t6_rst_hold", ret_valid, 0);
        push(2'd3, 16'h0077);
        chk("t6_rst_id3_miss", pe_valid, 0);
        push(2'd0, 16'h0066);
        chk("t6_rst_id0_hit", pe_ifmap, 16'h0066);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
